// File: rtl/inst_sequencer.sv
// Instruction sequencer: streams words from a local instruction memory to a
// consumer, one pulse-marked instruction per flag handshake, with jump/wrap/repeat control.
module inst_sequencer #(
  parameter int ADDR_BITS = 10,
  parameter int INST_BITS = 128,
  parameter int LOOP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 wea,
  input  logic [ADDR_BITS-1:0] addra,
  input  logic [INST_BITS-1:0] din,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] end_addr,
  input  logic [LOOP_BITS-1:0] loop_count,
  input  logic                 jmp,
  input  logic [ADDR_BITS-1:0] jmp_addr,
  input  logic                 force_inst,
  input  logic                 flag,
  output logic [INST_BITS-1:0] instruction,
  output logic                 init_inst_pulse,
  output logic                 complete_flag,
  output logic [ADDR_BITS-1:0] pc,
  output logic [LOOP_BITS-1:0] iter,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_PROC   = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_REPEAT = 2'b10
  } mode_e;

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [INST_BITS-1:0] mem [DEPTH];
  logic [INST_BITS-1:0] rd_data;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [ADDR_BITS-1:0] start_q, start_d;
  logic [ADDR_BITS-1:0] end_q, end_d;
  logic [LOOP_BITS-1:0] loop_q, loop_d;
  logic [LOOP_BITS-1:0] iter_q, iter_d;
  logic [INST_BITS-1:0] instr_q, instr_d;
  logic                 forced_q, forced_d;
  logic [LOOP_BITS-1:0] loop_last;
  mode_e                mode_dec;

  // NOTE: instruction memory has no reset; clearing it would forbid block-RAM mapping
  // and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= din;
  end

  // Sampling before the write lands gives read-old-data on a same-address collision.
  assign rd_data = mem[pc_q];

  assign loop_last = (loop_q == '0) ? '0 : loop_q - LOOP_BITS'(1);

  always_comb begin
    case (mode)
      2'b01:   mode_dec = MODE_WRAP;
      2'b10:   mode_dec = MODE_REPEAT;
      default: mode_dec = MODE_PROC;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves
  // a signal unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pc_d     = pc_q;
    start_d  = start_q;
    end_d    = end_q;
    loop_d   = loop_q;
    iter_d   = iter_q;
    instr_d  = instr_q;
    forced_d = forced_q;

    if (en) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_d   = mode_dec;
            start_d  = start_addr;
            end_d    = end_addr;
            loop_d   = loop_count;
            pc_d     = start_addr;
            iter_d   = '0;
            forced_d = 1'b0;
            state_d  = S_FETCH;
          end else if (state_q == S_IDLE && force_inst) begin
            instr_d  = din;
            forced_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end
        S_FETCH: begin
          instr_d = rd_data;
          state_d = S_ISSUE;
        end
        S_ISSUE:     state_d = S_WAIT_BUSY;
        S_WAIT_BUSY: if (!flag) state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (flag) begin
            if (forced_q) begin
              forced_d = 1'b0;
              state_d  = S_IDLE;
            end else if (jmp) begin
              pc_d    = jmp_addr;
              state_d = S_FETCH;
            end else if (pc_q != end_q) begin
              pc_d    = pc_q + ADDR_BITS'(1);
              state_d = S_FETCH;
            end else begin
              case (mode_q)
                MODE_WRAP: begin
                  pc_d    = start_q;
                  state_d = S_FETCH;
                end
                MODE_REPEAT: begin
                  if (iter_q == loop_last) begin
                    state_d = S_DONE;
                  end else begin
                    iter_d  = iter_q + LOOP_BITS'(1);
                    pc_d    = start_q;
                    state_d = S_FETCH;
                  end
                end
                default: state_d = S_DONE;
              endcase
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_PROC;
      pc_q     <= '0;
      start_q  <= '0;
      end_q    <= '0;
      loop_q   <= '0;
      iter_q   <= '0;
      instr_q  <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pc_q     <= pc_d;
      start_q  <= start_d;
      end_q    <= end_d;
      loop_q   <= loop_d;
      iter_q   <= iter_d;
      instr_q  <= instr_d;
      forced_q <= forced_d;
    end
  end

  // The pulse is decoded from state, so a stalled ISSUE fires once en returns.
  assign init_inst_pulse = en && (state_q == S_ISSUE);
  assign complete_flag   = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign instruction     = instr_q;
  assign pc              = pc_q;
  assign iter            = iter_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: stimulus pushes expected instructions,
// a negedge monitor pops and compares on every init_inst_pulse.
module tb_inst_sequencer;

  localparam int AW = 10;
  localparam int IW = 128;
  localparam int LW = 8;

  localparam logic [IW-1:0] INST_A = {4{32'hA0A0_0001}};
  localparam logic [IW-1:0] INST_B = {4{32'hB0B0_0002}};
  localparam logic [IW-1:0] INST_C = {4{32'hC0C0_0003}};
  localparam logic [IW-1:0] INST_D = {4{32'hD0D0_0004}};
  localparam logic [IW-1:0] INST_E = {4{32'hE0E0_00FF}};
  localparam logic [IW-1:0] INST_M0 = {4{32'h3FE0_3FE0}};
  localparam logic [IW-1:0] INST_M1 = {4{32'h3FF0_3FF0}};
  localparam logic [IW-1:0] INST_X = {4{32'h5A5A_C3C3}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          wea;
  logic [AW-1:0] addra;
  logic [IW-1:0] din;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [LW-1:0] loop_count;
  logic          jmp;
  logic [AW-1:0] jmp_addr;
  logic          force_inst;
  logic          flag;
  logic [IW-1:0] instruction;
  logic          init_inst_pulse;
  logic          complete_flag;
  logic [AW-1:0] pc;
  logic [LW-1:0] iter;
  logic          busy;

  // Consumer model: automatic responder or manual flag control.
  logic auto_resp = 1'b1;
  logic auto_flag = 1'b1;
  logic man_flag  = 1'b1;
  assign flag = auto_resp ? auto_flag : man_flag;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    bit            chk_pc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;
  int   base;

  always #5 clk = ~clk;

  inst_sequencer #(.ADDR_BITS(AW), .INST_BITS(IW), .LOOP_BITS(LW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .wea(wea), .addra(addra), .din(din),
    .start(start), .mode(mode), .start_addr(start_addr), .end_addr(end_addr),
    .loop_count(loop_count), .jmp(jmp), .jmp_addr(jmp_addr), .force_inst(force_inst),
    .flag(flag), .instruction(instruction), .init_inst_pulse(init_inst_pulse),
    .complete_flag(complete_flag), .pc(pc), .iter(iter), .busy(busy)
  );

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] i, input logic [AW-1:0] p, input bit c);
    exp_t e;
    e.instr  = i;
    e.pc     = p;
    e.chk_pc = c;
    sb_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (init_inst_pulse === 1'b1) begin
        pulse_cnt++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got instruction %0h with empty scoreboard", instruction);
        end else begin
          e = sb_q.pop_front();
          check("issued_instr", instruction, e.instr);
          if (e.chk_pc) check("issued_pc", IW'(pc), IW'(e.pc));
        end
      end
    end
  end

  // Automatic consumer: goes busy two cycles after a pulse, idle two cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_resp && init_inst_pulse === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 auto_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1 auto_flag = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
    @(posedge clk);
    #1 wea = 1'b1; addra = a; din = d;
    @(posedge clk);
    #1 wea = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [AW-1:0] sa,
                           input logic [AW-1:0] ea, input logic [LW-1:0] lc);
    @(posedge clk);
    #1 start = 1'b1; mode = m; start_addr = sa; end_addr = ea; loop_count = lc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (complete_flag !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, IW'(complete_flag), IW'(1));
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int c = 0;
    while ((pulse_cnt - base) < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, IW'(pulse_cnt - base), IW'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instruction"}, instruction, '0);
    check({tag, "_pulse"}, IW'(init_inst_pulse), '0);
    check({tag, "_complete"}, IW'(complete_flag), '0);
    check({tag, "_pc"}, IW'(pc), '0);
    check({tag, "_iter"}, IW'(iter), '0);
    check({tag, "_busy"}, IW'(busy), '0);
  endtask

  initial begin
    logic [IW-1:0] abcd [4];
    int flag_wait;
    abcd[0] = INST_A; abcd[1] = INST_B; abcd[2] = INST_C; abcd[3] = INST_D;

    reset_n = 1'b0; en = 1'b1; wea = 1'b0; addra = '0; din = '0; start = 1'b0;
    mode = 2'b00; start_addr = '0; end_addr = '0; loop_count = '0; jmp = 1'b0;
    jmp_addr = '0; force_inst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) wr(AW'(i), abcd[i]);
    wr(10'h0FF, INST_E);
    wr(10'h3FE, INST_M0);
    wr(10'h3FF, INST_M1);

    // Procedural run 0..3
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) push(abcd[i], AW'(i), 1'b1);
    start_run(2'b00, 10'h000, 10'h003, 8'd0);
    wait_done("proc_done", 200);
    check("proc_pulses", IW'(pulse_cnt - base), IW'(4));
    check("proc_busy", IW'(busy), IW'(0));
    check("proc_instr_held", instruction, INST_D);

    // Repeat-N, three passes
    base = pulse_cnt;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) push(abcd[i], AW'(i), 1'b1);
    start_run(2'b10, 10'h000, 10'h003, 8'd3);
    wait_done("rep3_done", 600);
    check("rep3_pulses", IW'(pulse_cnt - base), IW'(12));
    check("rep3_iter", IW'(iter), IW'(2));

    // Repeat-N with loop_count=0 behaves as one pass
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) push(abcd[i], AW'(i), 1'b1);
    start_run(2'b10, 10'h000, 10'h003, 8'd0);
    wait_done("rep0_done", 200);
    check("rep0_pulses", IW'(pulse_cnt - base), IW'(4));
    check("rep0_iter", IW'(iter), IW'(0));

    // Wrap mode for 10 instructions, then jump to 0x0FF
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) push(abcd[i % 4], AW'(i % 4), 1'b1);
    start_run(2'b01, 10'h000, 10'h003, 8'd0);
    wait_pulses("wrap_pulses", 10, 400);
    check("wrap_not_complete", IW'(complete_flag), IW'(0));
    jmp = 1'b1; jmp_addr = 10'h0FF;
    push(INST_E, 10'h0FF, 1'b1);
    wait_pulses("jump_pulse", 11, 100);
    jmp = 1'b0;

    // Reset while in WAIT_DONE
    flag_wait = 0;
    while (flag !== 1'b0 && flag_wait < 20) begin
      @(negedge clk);
      flag_wait++;
    end
    check("flag_went_busy", IW'(flag), IW'(0));
    @(posedge clk);
    #2;
    check("wait_done_busy", IW'(busy), IW'(1));
    reset_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    // Memory survives reset
    base = pulse_cnt;
    push(INST_A, 10'h000, 1'b1);
    push(INST_B, 10'h001, 1'b1);
    start_run(2'b00, 10'h000, 10'h001, 8'd0);
    wait_done("mem_kept_done", 200);
    check("mem_kept_pulses", IW'(pulse_cnt - base), IW'(2));

    // Forced instruction from IDLE
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base = pulse_cnt;
    push(INST_X, '0, 1'b0);
    @(posedge clk);
    #1 force_inst = 1'b1; din = INST_X;
    @(posedge clk);
    #1 force_inst = 1'b0;
    wait_pulses("force_pulse", 1, 20);
    repeat (10) @(negedge clk);
    check("force_pulses", IW'(pulse_cnt - base), IW'(1));
    check("force_idle_busy", IW'(busy), IW'(0));
    check("force_no_complete", IW'(complete_flag), IW'(0));
    check("force_instr_held", instruction, INST_X);

    // Address wrap-around 0x3FE..0x001
    base = pulse_cnt;
    push(INST_M0, 10'h3FE, 1'b1);
    push(INST_M1, 10'h3FF, 1'b1);
    push(INST_A, 10'h000, 1'b1);
    push(INST_B, 10'h001, 1'b1);
    start_run(2'b00, 10'h3FE, 10'h001, 8'd0);
    wait_done("awrap_done", 200);
    check("awrap_pulses", IW'(pulse_cnt - base), IW'(4));
    check("awrap_final_pc", IW'(pc), IW'(10'h001));

    // Stall in FETCH, then manual flag handshake
    auto_resp = 1'b0;
    man_flag  = 1'b1;
    base = pulse_cnt;
    push(INST_C, 10'h002, 1'b1);
    push(INST_D, 10'h003, 1'b1);
    start_run(2'b00, 10'h002, 10'h003, 8'd0);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_pc", IW'(pc), IW'(10'h002));
      check("stall_no_pulse", IW'(init_inst_pulse), IW'(0));
    end
    en = 1'b1;
    wait_pulses("stall_release", 1, 10);
    repeat (6) @(negedge clk);
    check("hold_no_advance_pulses", IW'(pulse_cnt - base), IW'(1));
    check("hold_pc", IW'(pc), IW'(10'h002));
    check("hold_busy", IW'(busy), IW'(1));
    check("hold_instr", instruction, INST_C);
    man_flag = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_phase_pc", IW'(pc), IW'(10'h002));
    man_flag = 1'b1;
    wait_pulses("handshake_advance", 2, 20);
    check("handshake_pc", IW'(pc), IW'(10'h003));
    man_flag = 1'b0;
    repeat (2) @(negedge clk);
    man_flag = 1'b1;
    wait_done("stall_done", 20);
    auto_resp = 1'b1;

    check("scoreboard_empty", IW'(sb_q.size()), IW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
